// File: rtl/fp_pkg.sv
// Shared constants and types for the FP round/pack stage.
// Optional FP_ROUND_MODE_EN adds the rounding-mode field to the stage-1 record.
package fp_pkg;

  localparam int FP_EXP_W  = 10;
  localparam int FP_FRAC_W = 33;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } rm_e;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [23:0]         mant24;
    logic                inc;
    logic                inexact;
    logic                zero;
    logic                inf;
    logic                nan;
`ifdef FP_ROUND_MODE_EN
    rm_e                 rm;
`endif
  } s1_t;

endpackage

// File: rtl/fp_round_pack_if.sv
// Upstream and downstream valid/ready bus of the round/pack stage.
// FP_ROUND_MODE_EN adds the in_rm rounding-mode field.
interface fp_round_pack_if #(
  parameter int EXP_W  = 10,
  parameter int FRAC_W = 33
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [FRAC_W-1:0] in_frac;
  logic              in_zero;
  logic              in_inf;
  logic              in_nan;
`ifdef FP_ROUND_MODE_EN
  logic [1:0]        in_rm;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic              out_inexact;
  logic              out_overflow;
  logic              out_underflow;

  modport master (
`ifdef FP_ROUND_MODE_EN
    output in_rm,
`endif
    output in_valid, in_sign, in_exp, in_frac, in_zero, in_inf, in_nan,
    input  in_ready,
    input  out_valid, out_result, out_inexact, out_overflow, out_underflow,
    output out_ready
  );

  modport slave (
`ifdef FP_ROUND_MODE_EN
    input  in_rm,
`endif
    input  in_valid, in_sign, in_exp, in_frac, in_zero, in_inf, in_nan,
    output in_ready,
    output out_valid, out_result, out_inexact, out_overflow, out_underflow,
    input  out_ready
  );
endinterface

// File: rtl/fp_round_pack_pipe_ctrl.sv
// Two-slot elastic pipeline control: per-stage valid flops and load enables.
// in_ready depends combinationally on out_ready only; valid never feeds through.
module fp_round_pack_pipe_ctrl (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic s1_load,
  output logic s2_load,
  output logic out_valid
);

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_adv, s2_adv;

  always_comb begin
    s2_adv     = !s2_valid_q | out_ready;
    s1_adv     = s2_adv | !s1_valid_q;
    in_ready   = s1_adv;
    s1_load    = s1_adv & in_valid;
    s2_load    = s2_adv & s1_valid_q;
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign out_valid = s2_valid_q;

endmodule

// File: rtl/fp_round_pack.sv
// Final add/sub stage: carry shift, rounding, exponent range handling, binary32 pack.
// FP_ROUND_MODE_EN enables selectable rounding modes; otherwise RNE is fixed.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int FRAC_W = FP_FRAC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_round_pack_if.slave  bus
);

  localparam logic signed [EXP_W-1:0] EXP_OVF  = EXP_W'(EXP_MAX);
  localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;

  logic s1_load, s2_load;

  fp_round_pack_pipe_ctrl u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .out_ready (bus.out_ready),
    .in_ready  (bus.in_ready),
    .s1_load   (s1_load),
    .s2_load   (s2_load),
    .out_valid (bus.out_valid)
  );

  s1_t s1_q, s1_d;

  logic [FRAC_W-2:0] frac_n;
  logic [EXP_W-1:0]  exp_n;
  logic              drop, lsb, g, r, s, inc;

  always_comb begin
    frac_n = bus.in_frac[FRAC_W-2:0];
    exp_n  = bus.in_exp;
    drop   = 1'b0;
    if (bus.in_frac[FRAC_W-1]) begin
      frac_n = bus.in_frac[FRAC_W-1:1];
      exp_n  = bus.in_exp + EXP_W'(1);
      drop   = bus.in_frac[0];
    end
    lsb = frac_n[8];
    g   = frac_n[7];
    r   = frac_n[6];
    s   = (|frac_n[5:0]) | drop;
`ifdef FP_ROUND_MODE_EN
    case (rm_e'(bus.in_rm))
      RM_RNE:  inc = g & (r | s | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = bus.in_sign & (g | r | s);
      RM_RUP:  inc = !bus.in_sign & (g | r | s);
      default: inc = 1'b0;
    endcase
`else
    inc = g & (r | s | lsb);
`endif

    s1_d = s1_q;
    if (s1_load) begin
      s1_d.sign    = bus.in_sign;
      s1_d.exp     = exp_n;
      s1_d.mant24  = frac_n[31:8];
      s1_d.inc     = inc;
      s1_d.inexact = g | r | s;
      s1_d.zero    = bus.in_zero;
      s1_d.inf     = bus.in_inf;
      s1_d.nan     = bus.in_nan;
`ifdef FP_ROUND_MODE_EN
      s1_d.rm      = rm_e'(bus.in_rm);
`endif
    end
  end

  logic [24:0]             m25;
  logic [EXP_W-1:0]        exp_r;
  logic signed [EXP_W-1:0] exp_s;
  logic [22:0]             mant;
  logic                    max_finite;
  logic                    unused_hidden;

  logic [31:0] result_q, result_d;
  logic        inexact_q, inexact_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  assign unused_hidden = m25[23];

  always_comb begin
    m25   = {1'b0, s1_q.mant24} + {24'd0, s1_q.inc};
    exp_r = s1_q.exp + {{(EXP_W-1){1'b0}}, m25[24]};
    exp_s = $signed(exp_r);
    // A carry out of rounding leaves 1.000..., so the stored mantissa is zero.
    mant  = m25[24] ? 23'd0 : m25[22:0];
`ifdef FP_ROUND_MODE_EN
    max_finite = (s1_q.rm == RM_RTZ) || (s1_q.rm == RM_RDN && !s1_q.sign) ||
                 (s1_q.rm == RM_RUP && s1_q.sign);
`else
    max_finite = 1'b0;
`endif

    result_d    = result_q;
    inexact_d   = inexact_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (s2_load) begin
      inexact_d   = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (s1_q.nan) begin
        result_d = QNAN;
      end else if (s1_q.inf) begin
        result_d = {s1_q.sign, 8'hFF, 23'd0};
      end else if (s1_q.zero) begin
        result_d = {s1_q.sign, 31'd0};
      end else if (exp_s >= EXP_OVF) begin
        result_d   = max_finite ? {s1_q.sign, 8'hFE, 23'h7FFFFF} : {s1_q.sign, 8'hFF, 23'd0};
        overflow_d = 1'b1;
        inexact_d  = 1'b1;
      end else if (exp_s <= EXP_ZERO) begin
        result_d    = {s1_q.sign, 31'd0};
        underflow_d = 1'b1;
        inexact_d   = 1'b1;
      end else begin
        result_d  = {s1_q.sign, exp_r[7:0], mant};
        inexact_d = s1_q.inexact;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      result_q    <= '0;
      inexact_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      result_q    <= result_d;
      inexact_q   <= inexact_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.out_result    = result_q;
  assign bus.out_inexact   = inexact_q;
  assign bus.out_overflow  = overflow_q;
  assign bus.out_underflow = underflow_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Scoreboard bench for fp_round_pack: arithmetic reference model, randomized and directed beats,
// backpressure and mid-stream reset.
module tb_fp_round_pack;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fp_round_pack_if #(.EXP_W(10), .FRAC_W(33)) bus ();

  fp_round_pack dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        inx;
    logic        ovf;
    logic        unf;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  int   low_cnt = 0;
  int   acc_cnt = 0;
  int   first_stall = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: value-level rounding of frac / 2^shift, no bit-field decomposition.
  function automatic exp_t model(bit sgn, int e, logic [32:0] frac, bit z, bit fi, bit fn, bit [1:0] rm);
    exp_t   x;
    longint f, m, rem, half;
    int     sh, ex;
    bit     up, mx;
    x.res = '0; x.inx = 0; x.ovf = 0; x.unf = 0; x.cyc = 0; x.lat = 0;
    if (fn) begin x.res = QNAN; return x; end
    if (fi) begin x.res = {sgn, 8'hFF, 23'd0}; return x; end
    if (z)  begin x.res = {sgn, 31'd0}; return x; end
    f    = longint'(frac);
    sh   = frac[32] ? 9 : 8;
    ex   = e + (frac[32] ? 1 : 0);
    m    = f >> sh;
    rem  = f - (m << sh);
    half = longint'(1) << (sh - 1);
    case (rm)
      2'd0:    up = (rem > half) || (rem == half && m[0]);
      2'd1:    up = 0;
      2'd2:    up = sgn && (rem != 0);
      default: up = !sgn && (rem != 0);
    endcase
    m = m + (up ? 1 : 0);
    if (m == (longint'(1) << 24)) begin
      m = longint'(1) << 23;
      ex++;
    end
    mx = (rm == 2'd1) || (rm == 2'd2 && !sgn) || (rm == 2'd3 && sgn);
    if (ex >= EXP_MAX) begin
      x.ovf = 1; x.inx = 1;
      x.res = mx ? {sgn, 8'hFE, 23'h7FFFFF} : {sgn, 8'hFF, 23'd0};
    end else if (ex <= 0) begin
      x.unf = 1; x.inx = 1;
      x.res = {sgn, 31'd0};
    end else begin
      x.inx = (rem != 0);
      x.res = {sgn, ex[7:0], m[22:0]};
    end
    return x;
  endfunction

  // Drive one beat from the negedge and hold it until accepted; returns just after the accepting edge.
  task automatic send(input bit sgn, input int e, input logic [32:0] f, input bit z, input bit fi,
                      input bit fn, input bit [1:0] rm, input bit lat);
    int   waited = 0;
    bit   r;
    exp_t x;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = sgn;
    bus.in_exp   = 10'(e);
    bus.in_frac  = f;
    bus.in_zero  = z;
    bus.in_inf   = fi;
    bus.in_nan   = fn;
`ifdef FP_ROUND_MODE_EN
    bus.in_rm    = rm;
`endif
    forever begin
      #4;
      r = bus.in_ready;
      if (r) begin
        x     = model(sgn, e, f, z, fi, fn, rm);
        x.cyc = cyc;
        x.lat = lat;
        sb.push_back(x);
        acc_cnt++;
        @(posedge clk);
        break;
      end
      if (first_stall < 0) first_stall = acc_cnt;
      waited++;
      if (waited > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL in_ready_timeout: in_ready stuck at %0b for %0d cycles", r, waited);
        bus.in_valid = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic rand_beat(input bit lat);
    int          e;
    logic [32:0] f;
    bit          z, fi, fn, sgn;
    bit [1:0]    rm;
    int          kind;
    kind = int'($urandom_range(0, 9));
    e    = int'($urandom_range(0, 320)) - 30;
    f    = {2'b01, 31'($urandom)};
    sgn  = 1'($urandom);
    case (kind)
      0, 1: f = {1'b1, 32'($urandom)};
      2:    f[7:0] = 8'h80;
      3:    f[30:7] = '1;
      4:    f = {1'b1, 23'($urandom), 9'h100};
      5:    e = int'($urandom_range(251, 256));
      6:    e = int'($urandom_range(0, 4)) - 2;
      default: ;
    endcase
    z  = ($urandom_range(0, 15) == 0);
    fi = ($urandom_range(0, 15) == 0);
    fn = ($urandom_range(0, 15) == 0);
`ifdef FP_ROUND_MODE_EN
    rm = 2'($urandom);
`else
    rm = 2'd0;
`endif
    send(sgn, e, f, z, fi, fn, rm, lat);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        2: if (low_cnt > 0) begin
             bus.out_ready = 1'b0;
             low_cnt--;
           end else begin
             bus.out_ready = 1'b1;
           end
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", bus.out_result);
        end else begin
          x = sb.pop_front();
          check("result", bus.out_result, x.res);
          check("inexact", 32'(bus.out_inexact), 32'(x.inx));
          check("overflow", 32'(bus.out_overflow), 32'(x.ovf));
          check("underflow", 32'(bus.out_underflow), 32'(x.unf));
          if (x.lat) check("latency", 32'(cyc - x.cyc), 32'd2);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_frac = '0;
    bus.in_zero = 1'b0; bus.in_inf = 1'b0; bus.in_nan = 1'b0;
`ifdef FP_ROUND_MODE_EN
    bus.in_rm = 2'd0;
`endif
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_result", bus.out_result, 32'd0);
    check("rst_flags", {29'd0, bus.out_inexact, bus.out_overflow, bus.out_underflow}, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // Directed cases, back-to-back with out_ready high, latency checked.
    ready_mode = 0;
    send(0, EXP_BIAS, 33'h080000000, 0, 0, 0, 2'd0, 1);
    send(0, EXP_BIAS, 33'h080000080, 0, 0, 0, 2'd0, 1);
    send(0, EXP_BIAS, 33'h080000180, 0, 0, 0, 2'd0, 1);
    send(0, EXP_BIAS, 33'h0FFFFFF80, 0, 0, 0, 2'd0, 1);
    send(0, EXP_BIAS, 33'h100000000, 0, 0, 0, 2'd0, 1);
    send(0, 254,      33'h0FFFFFF80, 0, 0, 0, 2'd0, 1);
    send(1, 0,        33'h080000000, 0, 0, 0, 2'd0, 1);
    send(0, 255,      33'h080000000, 0, 0, 0, 2'd0, 1);
    send(0, 1,        33'h080000000, 0, 0, 0, 2'd0, 1);
    send(1, -1,       33'h100000001, 0, 0, 0, 2'd0, 1);
    send(0, EXP_BIAS, 33'h080000000, 0, 1, 1, 2'd0, 1);
    send(1, EXP_BIAS, 33'h080000000, 0, 1, 0, 2'd0, 1);
    send(1, EXP_BIAS, 33'h080000000, 1, 0, 0, 2'd0, 1);
    send(0, EXP_BIAS, 33'h080000040, 0, 0, 0, 2'd0, 1);
    send(0, EXP_BIAS, 33'h0800000C0, 0, 0, 0, 2'd0, 1);
    idle();
    drain();

    // Random traffic under random backpressure and input gaps.
    ready_mode = 1;
    for (int i = 0; i < 400; i++) begin
      rand_beat(0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    ready_mode = 0;
    drain();

    // Five back-to-back beats with out_ready low for four cycles.
    acc_cnt = 0;
    first_stall = -1;
    low_cnt = 4;
    ready_mode = 2;
    for (int i = 0; i < 5; i++) rand_beat(0);
    idle();
    check("accepted_before_stall", 32'(first_stall), 32'd2);
    ready_mode = 0;
    drain();

    // Mid-stream reset discards in-flight beats.
    ready_mode = 3;
    send(0, EXP_BIAS, 33'h0C0000000, 0, 0, 0, 2'd0, 0);
    send(1, 130,      33'h0A0000000, 0, 0, 0, 2'd0, 0);
    idle();
    @(negedge clk);
    #4;
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_result", bus.out_result, 32'd0);
    check("mid_rst_flags", {29'd0, bus.out_inexact, bus.out_overflow, bus.out_underflow}, 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
